mpsoc_msi_ahb2apb_bridge: RTL and testbench
===========================================

Name:
mpsoc_msi_ahb2apb_bridge

Overview:
- AHB-Lite slave to APB bridge. Connects to one slave port of the MSI AHB-Lite crossbar and converts each AHB transfer into exactly one APB transfer.
- Sits directly downstream of a crossbar slave port (slv_* bundle) and drives a peripheral APB segment.
- Single clock domain; all AHB-side outputs are registered.

Parameters:
- PLEN, 64, AHB address width
- XLEN, 64, AHB and APB data width; APB PDATA equals XLEN
- PADDR_SIZE, 16, APB address width; PADDR = HADDR[PADDR_SIZE-1:0]

Ports:
- HCLK  input  1  clock, rising edge
- HRESETn  input  1  asynchronous active-low reset
- HSEL  input  1  slave select from crossbar slv_HSEL
- HADDR  input  PLEN  address
- HWDATA  input  XLEN  write data, valid in data phase
- HRDATA  output  XLEN  read data
- HWRITE  input  1  1=write
- HSIZE  input  3  transfer size
- HBURST  input  3  burst type, ignored; each beat is handled as a single
- HPROT  input  4  protection
- HTRANS  input  2  IDLE/BUSY/NONSEQ/SEQ
- HMASTLOCK  input  1  ignored
- HREADY  input  1  combined bus HREADY
- HREADYOUT  output  1  bridge ready
- HRESP  output  1  0=OKAY, 1=ERROR
- PSEL  output  1  APB select
- PENABLE  output  1  APB enable
- PADDR  output  PADDR_SIZE  APB address
- PWRITE  output  1  APB direction
- PWDATA  output  XLEN  APB write data
- PRDATA  input  XLEN  APB read data
- PREADY  input  1  APB ready
- PSLVERR  input  1  APB error
- PSTRB  output  XLEN/8  byte strobes; present only with the optional feature
- PPROT  output  3  protection; present only with the optional feature

Behaviour:
- Reset (asynchronous, any state, including mid-transfer):
  - FSM goes to IDLE.
  - HREADYOUT=1, HRESP=0, HRDATA=0.
  - PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0.
  - Any APB transfer in flight is abandoned.
- Accept condition: HSEL & HREADY & HTRANS[1]. Checked only in states IDLE, DONE and ERR2.
  - On accept, latch HADDR[PADDR_SIZE-1:0], HWRITE, HSIZE, HPROT.
  - IDLE or BUSY transfers are not accepted; the bridge stays in, or returns to, IDLE with OKAY and zero wait states.
- Size check on accept: if HSIZE > log2(XLEN/8), go to ERR1 with no APB transfer.
- States and per-state outputs:
  - IDLE: HREADYOUT=1, HRESP=0.
    - Accepted read -> SETUP.
    - Accepted write -> WLOAD.
  - WLOAD: HREADYOUT=0. Capture HWDATA into PWDATA, then -> SETUP.
  - SETUP: PSEL=1, PENABLE=0, HREADYOUT=0. PADDR and PWRITE are driven from the latches. -> ACCESS.
  - ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0. PADDR, PWRITE and PWDATA are held stable.
    - PREADY=0: stay in ACCESS. No timeout.
    - PREADY=1, PSLVERR=0: capture PRDATA into HRDATA (reads only), -> DONE.
    - PREADY=1, PSLVERR=1: -> ERR1.
  - DONE: PSEL=0, PENABLE=0, HREADYOUT=1, HRESP=0. Accept is evaluated as in IDLE; no accept -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1, PSEL=0. -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. This is the second cycle of the two-cycle AHB ERROR response. Accept is evaluated (the master may also cancel with IDLE); no accept -> IDLE.
- Latency with zero-wait APB (address phase = cycle 0):
  - Read: SETUP at 1, ACCESS at 2, HREADYOUT high at 3.
  - Write: WLOAD at 1, SETUP at 2, ACCESS at 3, HREADYOUT high at 4.
  - Each PREADY-low cycle adds one cycle.
- Back-to-back transfers: an accept in DONE or ERR2 goes straight to SETUP or WLOAD. There is no idle APB cycle beyond DONE.
- HRDATA holds its last captured value until the next successful read completes. It is not updated on writes or errors.
- PSEL never asserts for a size-error transfer.

Optional Feature:
- Macro: MPSOC_MSI_APB4_EN.
- Defined:
  - PSTRB and PPROT ports exist.
  - PSTRB: (2^HSIZE) ones shifted left by HADDR[log2(XLEN/8)-1:0] & ~((2^HSIZE)-1). It is forced to 0 on reads.
  - PPROT = {~HPROT[0], 1'b1, HPROT[1]}.
  - Both are latched on accept and are 0 in reset and when PSEL=0.
- Undefined:
  - Both ports are absent.
  - Peripherals treat every write as full-word. Size checking is unchanged.

Test Plan:
- Read, PREADY=1 immediately, HADDR=0x1234, PRDATA=0xDEADBEEF -> PADDR=0x1234 at cycles 1-2, PENABLE only at 2, HREADYOUT=0 at 1-2, HREADYOUT=1 and HRDATA=0xDEADBEEF at 3.
- Write, HWDATA=0xA5A5 at cycle 1, PREADY low for 3 ACCESS cycles -> PWDATA=0xA5A5 and PWRITE=1 stable from cycle 2 to 6, HREADYOUT=1 at 7.
- Read with PREADY=1 and PSLVERR=1 -> ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (HREADYOUT=1, HRESP=1); HRDATA unchanged.
- HSIZE=3'b111 with XLEN=64 -> no PSEL pulse, two-cycle ERROR response.
- Two back-to-back NONSEQ reads, second accepted in DONE -> second SETUP immediately follows DONE; HTRANS=BUSY/IDLE -> HREADYOUT stays 1 and PSEL stays 0.
- HRESETn low during ACCESS -> PSEL and PENABLE drop immediately, HREADYOUT=1, HRDATA=0; with APB4 enabled, a byte write at HADDR[2:0]=5 with HSIZE=0 -> PSTRB=8'b00100000.

Source files
------------

// File: rtl/mpsoc_msi_ahb2apb_bridge.sv
// AHB-Lite slave to APB bridge: each accepted AHB transfer becomes exactly one APB transfer.
// Optional APB4 sideband (PSTRB/PPROT) is enabled by defining MPSOC_MSI_APB4_EN.
module mpsoc_msi_ahb2apb_bridge #(
    parameter int PLEN       = 64,
    parameter int XLEN       = 64,
    parameter int PADDR_SIZE = 16
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic                  HSEL,
    input  logic [PLEN-1:0]       HADDR,
    input  logic [XLEN-1:0]       HWDATA,
    output logic [XLEN-1:0]       HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HMASTLOCK,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [PADDR_SIZE-1:0] PADDR,
    output logic                  PWRITE,
    output logic [XLEN-1:0]       PWDATA,
    input  logic [XLEN-1:0]       PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
`ifdef MPSOC_MSI_APB4_EN
    ,
    output logic [XLEN/8-1:0]     PSTRB,
    output logic [2:0]            PPROT
`endif
);

    localparam int         BW       = XLEN / 8;
    localparam int         SZ_MAX   = $clog2(BW);
    localparam logic [2:0] SZ_MAX_C = 3'(SZ_MAX);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WLOAD  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4,
        ST_ERR1   = 3'd5,
        ST_ERR2   = 3'd6
    } state_t;

    state_t                  state_r;
    logic [PADDR_SIZE-1:0]   addr_r;
    logic                    write_r;
    logic                    accept_s;
    logic                    size_err_s;
    logic                    unused_s;

    assign accept_s   = HSEL & HREADY & HTRANS[1];
    assign size_err_s = (HSIZE > SZ_MAX_C);

`ifdef MPSOC_MSI_APB4_EN
    logic [BW-1:0] strb_r;
    logic [2:0]    pprot_r;

    // Byte lanes covered by a naturally aligned transfer of 2^size bytes.
    function automatic logic [BW-1:0] strb_f(input logic [2:0] size, input logic [SZ_MAX-1:0] offs);
        int            nbytes;
        int            base;
        logic [BW-1:0] strb;
        nbytes = int'(32'd1 << size);
        base   = int'(offs) & ~(nbytes - 32'sd1);
        for (int i = 0; i < BW; i++) begin
            strb[i] = (i >= base) && (i < base + nbytes);
        end
        return strb;
    endfunction

    assign unused_s = ^{HBURST, HMASTLOCK, HTRANS[0], HPROT[3:2], HADDR[PLEN-1:PADDR_SIZE]};
`else
    assign unused_s = ^{HBURST, HMASTLOCK, HTRANS[0], HPROT, HADDR[PLEN-1:PADDR_SIZE]};
`endif

    // Bridge FSM with all AHB- and APB-side outputs registered.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_r   <= ST_IDLE;
            addr_r    <= '0;
            write_r   <= 1'b0;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PWDATA    <= '0;
`ifdef MPSOC_MSI_APB4_EN
            strb_r    <= '0;
            pprot_r   <= 3'b000;
            PSTRB     <= '0;
            PPROT     <= 3'b000;
`endif
        end else begin
            case (state_r)
                // Only these states may take a new address phase.
                ST_IDLE, ST_DONE, ST_ERR2: begin
                    if (accept_s) begin
                        addr_r    <= HADDR[PADDR_SIZE-1:0];
                        write_r   <= HWRITE;
                        HREADYOUT <= 1'b0;
`ifdef MPSOC_MSI_APB4_EN
                        strb_r    <= HWRITE ? strb_f(HSIZE, HADDR[SZ_MAX-1:0]) : '0;
                        pprot_r   <= {~HPROT[0], 1'b1, HPROT[1]};
`endif
                        if (size_err_s) begin
                            state_r <= ST_ERR1;
                            HRESP   <= 1'b1;
                        end else if (HWRITE) begin
                            state_r <= ST_WLOAD;
                            HRESP   <= 1'b0;
                        end else begin
                            state_r <= ST_SETUP;
                            HRESP   <= 1'b0;
                            PSEL    <= 1'b1;
                            PADDR   <= HADDR[PADDR_SIZE-1:0];
                            PWRITE  <= 1'b0;
`ifdef MPSOC_MSI_APB4_EN
                            PSTRB   <= '0;
                            PPROT   <= {~HPROT[0], 1'b1, HPROT[1]};
`endif
                        end
                    end else begin
                        state_r   <= ST_IDLE;
                        HREADYOUT <= 1'b1;
                        HRESP     <= 1'b0;
                    end
                end
                // HWDATA is valid in the data phase, one cycle after accept.
                ST_WLOAD: begin
                    state_r <= ST_SETUP;
                    PWDATA  <= HWDATA;
                    PSEL    <= 1'b1;
                    PADDR   <= addr_r;
                    PWRITE  <= write_r;
`ifdef MPSOC_MSI_APB4_EN
                    PSTRB   <= strb_r;
                    PPROT   <= pprot_r;
`endif
                end
                ST_SETUP: begin
                    state_r <= ST_ACCESS;
                    PENABLE <= 1'b1;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        PSEL    <= 1'b0;
                        PENABLE <= 1'b0;
`ifdef MPSOC_MSI_APB4_EN
                        PSTRB   <= '0;
                        PPROT   <= 3'b000;
`endif
                        if (PSLVERR) begin
                            state_r <= ST_ERR1;
                            HRESP   <= 1'b1;
                        end else begin
                            state_r   <= ST_DONE;
                            HREADYOUT <= 1'b1;
                            if (!write_r) begin
                                HRDATA <= PRDATA;
                            end
                        end
                    end else begin
                        state_r <= ST_ACCESS;
                    end
                end
                ST_ERR1: begin
                    state_r   <= ST_ERR2;
                    HREADYOUT <= 1'b1;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    HREADYOUT <= 1'b1;
                    HRESP     <= 1'b0;
                    PSEL      <= 1'b0;
                    PENABLE   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mpsoc_msi_ahb2apb_bridge.sv
// Self-checking bench for mpsoc_msi_ahb2apb_bridge: directed cases plus randomized transfers
// checked against a transfer-level model (latency, APB pulse shape, response, read data).
module tb_mpsoc_msi_ahb2apb_bridge;

    localparam int PLEN       = 64;
    localparam int XLEN       = 64;
    localparam int PADDR_SIZE = 16;

    logic                  HCLK = 1'b0;
    logic                  HRESETn;
    logic                  HSEL;
    logic [PLEN-1:0]       HADDR;
    logic [XLEN-1:0]       HWDATA;
    logic [XLEN-1:0]       HRDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic                  HREADY;
    logic                  HREADYOUT;
    logic                  HRESP;
    logic                  PSEL;
    logic                  PENABLE;
    logic [PADDR_SIZE-1:0] PADDR;
    logic                  PWRITE;
    logic [XLEN-1:0]       PWDATA;
    logic [XLEN-1:0]       PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;
`ifdef MPSOC_MSI_APB4_EN
    logic [XLEN/8-1:0]     PSTRB;
    logic [2:0]            PPROT;
`endif

    mpsoc_msi_ahb2apb_bridge #(.PLEN(PLEN), .XLEN(XLEN), .PADDR_SIZE(PADDR_SIZE)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT),
        .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK), .HREADY(HREADY), .HREADYOUT(HREADYOUT),
        .HRESP(HRESP), .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
`ifdef MPSOC_MSI_APB4_EN
        , .PSTRB(PSTRB), .PPROT(PPROT)
`endif
    );

    always #5 HCLK = ~HCLK;

    int n_tests = 0;
    int n_fail  = 0;
    logic [XLEN-1:0] model_rdata = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic idle();
        HSEL   = 1'b0;
        HTRANS = 2'b00;
        tick();
    endtask

    // One AHB transfer; returns in the cycle the bridge shows HREADYOUT=1 again.
    task automatic xfer(input logic w, input logic [63:0] addr, input logic [2:0] size,
                        input logic [63:0] wdata, input int waits, input logic err,
                        input logic [63:0] rdata, input logic [3:0] prot);
        int   cyc, psel_n, pen_n, first_pen, acc, exp_lat, nbytes, base;
        logic bad_addr, bad_wr, bad_wd, bad4, prev_resp, done, size_err;
        logic [7:0] exp_strb;
        logic [2:0] exp_pprot;
        size_err = (size > 3'd3);
        nbytes   = 1 << size;
        base     = (int'(addr[2:0]) / nbytes) * nbytes;
        exp_strb = (w && !size_err) ? 8'(((1 << nbytes) - 1) << base) : 8'h00;
        exp_pprot = {~prot[0], 1'b1, prot[1]};
        psel_n = 0; pen_n = 0; first_pen = -1; acc = 0;
        bad_addr = 1'b0; bad_wr = 1'b0; bad_wd = 1'b0; bad4 = 1'b0; prev_resp = 1'b0; done = 1'b0;

        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = w; HSIZE = size; HPROT = prot;
        HREADY = 1'b1; PREADY = 1'b0; PSLVERR = 1'b0;
        tick();
        cyc = 1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = wdata;
        while (!done && cyc < 60) begin
            if (HREADYOUT === 1'b1) begin
                done = 1'b1;
            end else begin
                prev_resp = HRESP;
                PREADY = 1'b0; PSLVERR = 1'b0;
                if (PSEL === 1'b1) begin
                    psel_n++;
                    if (PADDR !== addr[15:0]) bad_addr = 1'b1;
                    if (PWRITE !== w) bad_wr = 1'b1;
                    if (w && PWDATA !== wdata) bad_wd = 1'b1;
`ifdef MPSOC_MSI_APB4_EN
                    if (PSTRB !== exp_strb || PPROT !== exp_pprot) bad4 = 1'b1;
                end else begin
                    if (PSTRB !== 8'h00 || PPROT !== 3'b000) bad4 = 1'b1;
`endif
                end
                if (PENABLE === 1'b1) begin
                    pen_n++;
                    if (first_pen < 0) first_pen = cyc;
                    if (acc == waits) begin
                        PREADY = 1'b1; PSLVERR = err; PRDATA = rdata;
                    end
                    acc++;
                end
                tick();
                cyc++;
            end
        end
        PREADY = 1'b0; PSLVERR = 1'b0;

        if (size_err)  exp_lat = 2;
        else if (err)  exp_lat = (w ? 5 : 4) + waits;
        else           exp_lat = (w ? 4 : 3) + waits;
        if (!w && !err && !size_err) model_rdata = rdata;

        check("latency", 64'(cyc), 64'(exp_lat));
        check("hresp_final", {63'd0, HRESP}, {63'd0, (err | size_err)});
        check("hresp_prev", {63'd0, prev_resp}, {63'd0, (err | size_err)});
        check("psel_cycles", 64'(psel_n), size_err ? 64'd0 : 64'(waits + 2));
        check("penable_cycles", 64'(pen_n), size_err ? 64'd0 : 64'(waits + 1));
        check("first_penable", 64'(first_pen), size_err ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(w ? 3 : 2));
        check("psel_at_end", {63'd0, PSEL}, 64'd0);
        check("paddr_stable", {63'd0, bad_addr}, 64'd0);
        check("pwrite_stable", {63'd0, bad_wr}, 64'd0);
        check("pwdata_stable", {63'd0, bad_wd}, 64'd0);
        check("apb4_sideband", {63'd0, bad4}, 64'd0);
        check("hrdata", HRDATA, model_rdata);
    endtask

    initial begin
        logic       w, err, b2b;
        logic [2:0] size;
        HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HWDATA = '0; HWRITE = 1'b0; HSIZE = 3'd0;
        HBURST = 3'd0; HPROT = 4'd0; HTRANS = 2'b00; HMASTLOCK = 1'b0; HREADY = 1'b1;
        PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        tick(); tick();
        check("rst_hreadyout", {63'd0, HREADYOUT}, 64'd1);
        check("rst_hresp", {63'd0, HRESP}, 64'd0);
        check("rst_hrdata", HRDATA, 64'd0);
        check("rst_psel_penable", {62'd0, PSEL, PENABLE}, 64'd0);
        check("rst_paddr_pwrite", {47'd0, PADDR, PWRITE}, 64'd0);
        check("rst_pwdata", PWDATA, 64'd0);
        HRESETn = 1'b1;
        tick();

        // Zero-wait read, then a write stretched by three PREADY-low cycles.
        xfer(1'b0, 64'h1234, 3'd3, 64'd0, 0, 1'b0, 64'hDEADBEEF, 4'b0011);
        idle();
        xfer(1'b1, 64'h2000, 3'd3, 64'hA5A5, 3, 1'b0, 64'd0, 4'b0000);
        idle();
        // Slave error on a read leaves HRDATA untouched; oversize transfer never selects APB.
        xfer(1'b0, 64'h3008, 3'd3, 64'd0, 1, 1'b1, 64'h0BAD, 4'b0001);
        idle();
        xfer(1'b0, 64'h0040, 3'd7, 64'd0, 0, 1'b0, 64'd0, 4'b0000);
        idle();
        // Back-to-back reads, and an accept taken in the second ERROR cycle.
        xfer(1'b0, 64'h0100, 3'd2, 64'd0, 0, 1'b0, 64'h1111, 4'b0000);
        xfer(1'b0, 64'h0108, 3'd2, 64'd0, 0, 1'b0, 64'h2222, 4'b0000);
        xfer(1'b1, 64'h0110, 3'd3, 64'h77, 0, 1'b1, 64'd0, 4'b0010);
        xfer(1'b0, 64'h0118, 3'd1, 64'd0, 2, 1'b0, 64'h3333, 4'b0000);
        idle();

        // BUSY, IDLE and a NONSEQ with HREADY low are all ignored.
        HSEL = 1'b1; HTRANS = 2'b01; tick();
        check("busy_ready", {62'd0, HREADYOUT, PSEL}, 64'd2);
        HTRANS = 2'b00; tick();
        check("idle_ready", {62'd0, HREADYOUT, PSEL}, 64'd2);
        HTRANS = 2'b10; HREADY = 1'b0; tick();
        check("hready_low_ready", {62'd0, HREADYOUT, PSEL}, 64'd2);
        HREADY = 1'b1;
        idle();

        // Byte write at offset 5 (lane 5 strobe when the APB4 sideband is present).
        xfer(1'b1, 64'h0005, 3'd0, 64'h0000_5A00_0000_0000, 0, 1'b0, 64'd0, 4'b0001);
        idle();

        for (int i = 0; i < 24; i++) begin
            w    = 1'($urandom_range(0, 1));
            size = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            err  = ($urandom_range(0, 5) == 0);
            b2b  = 1'($urandom_range(0, 1));
            xfer(w, {$urandom, $urandom}, size, {$urandom, $urandom}, int'($urandom_range(0, 3)),
                 err, {$urandom, $urandom}, 4'($urandom_range(0, 15)));
            if (!b2b) idle();
        end

        // Asynchronous reset in the middle of an ACCESS phase.
        idle();
        xfer(1'b0, 64'h0200, 3'd3, 64'd0, 0, 1'b0, 64'hCAFE, 4'b0000);
        idle();
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 64'h0300; HWRITE = 1'b0; HSIZE = 3'd3;
        tick();
        HSEL = 1'b0; HTRANS = 2'b00;
        tick();
        check("pre_reset_access", {62'd0, PSEL, PENABLE}, 64'd3);
        HRESETn = 1'b0;
        #1;
        check("reset_psel_penable", {62'd0, PSEL, PENABLE}, 64'd0);
        check("reset_hreadyout", {63'd0, HREADYOUT}, 64'd1);
        check("reset_hrdata", HRDATA, 64'd0);
        model_rdata = '0;
        tick();
        HRESETn = 1'b1;
        tick();
        xfer(1'b0, 64'h0400, 3'd3, 64'd0, 1, 1'b0, 64'h5555, 4'b0000);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
